gray_pixel_sequencer: RTL and testbench
=======================================

GRAY_PIXEL_SEQUENCER -- requirements
Module: gray_pixel_sequencer

Interface
REQ-001 The block SHALL have one parameter: NUM_PIXELS, 183184 (428*428), pixels per frame.
REQ-002 The block SHALL have these ports, one clock, with reset asynchronous and active-low:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  asynchronous active-low reset.
- i_frame_start  in  1  begin a frame; sampled in IDLE and DONE only.
- i_byte_valid  in  1  upstream byte stream valid.
- i_byte  in  8  RGB byte; three consecutive bytes form one pixel.
- o_byte_ready  out  1  byte accepted when high with i_byte_valid.
- o_grayscale_start  out  1  one-cycle start pulse to the grayscale converter.
- o_RGB  out  32  packed pixel to the converter.
- i_grayscale_data_ready  in  1  converter result valid.
- i_gray  in  8  converter result.
- o_gray_valid  out  1  result pixel valid downstream.
- o_gray_pixel  out  8  result pixel.
- i_gray_ready  in  1  downstream accepts when high with o_gray_valid.
- o_pixel_count  out  18  pixels emitted this frame.
- o_done  out  1  frame complete.

Function
REQ-003 The FSM SHALL have states IDLE, GATHER, START, WAIT, EMIT and DONE, and SHALL change state only on the rising clk edge.
REQ-004 IDLE SHALL keep o_byte_ready=0 and SHALL go to GATHER when i_frame_start=1, clearing o_pixel_count and the byte index.
REQ-005 GATHER SHALL drive o_byte_ready=1 and SHALL store byte k (k=0,1,2) on each cycle where i_byte_valid=1.
REQ-006 After the third byte is accepted, GATHER SHALL go to START on the next edge, and the byte index SHALL wrap to 0.
REQ-007 o_RGB SHALL equal {byte0, byte1, byte2, 8'h00}.
REQ-008 o_RGB SHALL be stable from entry to START until exit from WAIT.
REQ-009 START SHALL assert o_grayscale_start for exactly one cycle, then go to WAIT.
- Latency from the third byte accepted to the start pulse: 1 cycle.
REQ-010 i_grayscale_data_ready SHALL be sampled in WAIT only; it SHALL be ignored in every other state, including the START cycle.
REQ-011 In WAIT, i_grayscale_data_ready=1 SHALL latch i_gray into o_gray_pixel and go to EMIT.
- WAIT has no timeout.
REQ-012 EMIT SHALL hold o_gray_valid=1 with o_gray_pixel stable until i_gray_ready=1.
REQ-013 On the accepting edge in EMIT:
- o_pixel_count SHALL increment.
- The FSM SHALL go to DONE if the new count equals NUM_PIXELS, else to GATHER.
REQ-014 o_byte_ready SHALL be 0 in every state except GATHER, so no byte is consumed while a pixel is in flight.
REQ-015 DONE SHALL hold o_done=1 and o_pixel_count=NUM_PIXELS.
REQ-016 i_frame_start=1 in DONE SHALL clear o_done and o_pixel_count and go to GATHER.
REQ-017 i_frame_start SHALL be ignored in GATHER, START, WAIT and EMIT.
REQ-018 o_pixel_count SHALL never exceed NUM_PIXELS and SHALL not wrap.
REQ-019 i_byte_valid=0 in GATHER SHALL stall with the partial pixel retained; the byte index is unchanged.

Reset
REQ-020 n_rst=0 SHALL force IDLE immediately, asynchronously, from any state, including mid-pixel and mid-EMIT.
REQ-021 While n_rst=0 and after its release, the outputs SHALL be:
- o_byte_ready=0, o_grayscale_start=0, o_gray_valid=0, o_done=0.
- o_RGB=32'h0, o_gray_pixel=8'h0, o_pixel_count=0.
- Byte index cleared.
REQ-022 After reset release the block SHALL stay in IDLE until i_frame_start=1; a partial pixel held before reset SHALL be discarded.

Verification
REQ-023 The bench SHALL cover these scenarios:
- Basic pixel: NUM_PIXELS=1; frame_start, bytes 0x12,0x34,0x56 back-to-back -> o_RGB=0x12345600; start pulse 1 cycle after byte 3; converter model returns 0x40 after 3 cycles -> o_gray_pixel=0x40 valid; accept -> o_done=1, count=1.
- Stalls: gaps of 2 cycles between bytes and i_gray_ready low 4 cycles -> o_RGB unchanged, o_gray_pixel held, exactly one start pulse, o_byte_ready=0 outside GATHER.
- Spurious ready: i_grayscale_data_ready high during START and GATHER -> ignored, no EMIT entry.
- Full frame: NUM_PIXELS=4 with 12 random bytes vs. a reference luma model -> 4 outputs in order, o_done after the 4th, count=4; i_frame_start mid-frame ignored.
- Restart: i_frame_start in DONE -> o_done=0, count=0, next 3 bytes form a new pixel.
- Reset mid-op: n_rst low during WAIT after 2 pixels -> all outputs zero immediately; the next frame starts cleanly from byte 0.

Source files
------------

// File: rtl/gray_pixel_sequencer.sv
// Gathers RGB byte triplets into pixels, hands each to a grayscale converter
// and emits the converted gray pixel downstream, counting pixels per frame.
module gray_pixel_sequencer #(
  parameter int NUM_PIXELS = 183184
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        i_frame_start,
  input  logic        i_byte_valid,
  input  logic [7:0]  i_byte,
  output logic        o_byte_ready,
  output logic        o_grayscale_start,
  output logic [31:0] o_RGB,
  input  logic        i_grayscale_data_ready,
  input  logic [7:0]  i_gray,
  output logic        o_gray_valid,
  output logic [7:0]  o_gray_pixel,
  input  logic        i_gray_ready,
  output logic [17:0] o_pixel_count,
  output logic        o_done
);

  typedef enum logic [2:0] {
    IDLE,
    GATHER,
    START,
    WAIT,
    EMIT,
    DONE
  } state_t;

  localparam logic [17:0] LAST = 18'(NUM_PIXELS);

  state_t      state;
  logic [1:0]  idx;
  logic [7:0]  b0;
  logic [7:0]  b1;
  logic [31:0] rgb;
  logic [7:0]  gray;
  logic [17:0] cnt;
  logic [17:0] cnt_nxt;

  assign cnt_nxt = cnt + 18'd1;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
      idx   <= 2'd0;
      b0    <= 8'h00;
      b1    <= 8'h00;
      rgb   <= 32'h0;
      gray  <= 8'h00;
      cnt   <= 18'd0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (i_frame_start) begin
            cnt   <= 18'd0;
            idx   <= 2'd0;
            state <= GATHER;
          end
        end
        GATHER: begin
          if (i_byte_valid) begin
            unique case (idx)
              2'd0: begin
                b0  <= i_byte;
                idx <= 2'd1;
              end
              2'd1: begin
                b1  <= i_byte;
                idx <= 2'd2;
              end
              default: begin
                // o_RGB only changes here, so it holds through START/WAIT
                rgb   <= {b0, b1, i_byte, 8'h00};
                idx   <= 2'd0;
                state <= START;
              end
            endcase
          end
        end
        START: state <= WAIT;
        WAIT: begin
          if (i_grayscale_data_ready) begin
            gray  <= i_gray;
            state <= EMIT;
          end
        end
        EMIT: begin
          if (i_gray_ready) begin
            cnt   <= cnt_nxt;
            state <= (cnt_nxt == LAST) ? DONE : GATHER;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_byte_ready      = (state == GATHER);
  assign o_grayscale_start = (state == START);
  assign o_gray_valid      = (state == EMIT);
  assign o_done            = (state == DONE);
  assign o_RGB             = rgb;
  assign o_gray_pixel      = gray;
  assign o_pixel_count     = cnt;

endmodule

// File: tb/tb_gray_pixel_sequencer.sv
// Directed bench: a one-pixel and a four-pixel frame instance share stimulus;
// a table of pixel vectors drives the full-frame, restart and reset cases.
module tb_gray_pixel_sequencer;

  typedef struct {
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    int          gap;
    int          clat;
    int          rlat;
    logic [31:0] rgb;
  } vec_t;

  logic        tb_clk = 1'b0;
  logic        n_rst;
  logic        frame_start;
  logic        byte_valid;
  logic [7:0]  in_byte;
  logic        data_ready;
  logic [7:0]  in_gray;
  logic        gray_ready;

  logic        byte_ready, gs_start, gray_valid, done;
  logic [31:0] rgb;
  logic [7:0]  gray_pixel;
  logic [17:0] pix_cnt;

  logic        u1_byte_ready, u1_gs_start, u1_gray_valid, u1_done;
  logic [31:0] u1_rgb;
  logic [7:0]  u1_gray_pixel;
  logic [17:0] u1_pix_cnt;

  int pass_cnt = 0;
  int total    = 0;
  vec_t tbl [6];
  vec_t basic;

  always #5 tb_clk = ~tb_clk;

  gray_pixel_sequencer #(.NUM_PIXELS(4)) dut (
    .clk(tb_clk), .n_rst(n_rst),
    .i_frame_start(frame_start),
    .i_byte_valid(byte_valid), .i_byte(in_byte),
    .o_byte_ready(byte_ready),
    .o_grayscale_start(gs_start), .o_RGB(rgb),
    .i_grayscale_data_ready(data_ready), .i_gray(in_gray),
    .o_gray_valid(gray_valid), .o_gray_pixel(gray_pixel),
    .i_gray_ready(gray_ready),
    .o_pixel_count(pix_cnt), .o_done(done)
  );

  gray_pixel_sequencer #(.NUM_PIXELS(1)) u1 (
    .clk(tb_clk), .n_rst(n_rst),
    .i_frame_start(frame_start),
    .i_byte_valid(byte_valid), .i_byte(in_byte),
    .o_byte_ready(u1_byte_ready),
    .o_grayscale_start(u1_gs_start), .o_RGB(u1_rgb),
    .i_grayscale_data_ready(data_ready), .i_gray(in_gray),
    .o_gray_valid(u1_gray_valid), .o_gray_pixel(u1_gray_pixel),
    .i_gray_ready(gray_ready),
    .o_pixel_count(u1_pix_cnt), .o_done(u1_done)
  );

  function automatic logic [7:0] luma(input logic [7:0] r,
                                      input logic [7:0] g,
                                      input logic [7:0] b);
    int y;
    y = (77 * int'(r) + 150 * int'(g) + 29 * int'(b)) >> 8;
    return 8'(y);
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", name, act, exp);
    else
      pass_cnt++;
  endtask

  task automatic step();
    @(posedge tb_clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
    chk({tag, "_start"}, 32'(gs_start), 32'd0);
    chk({tag, "_valid"}, 32'(gray_valid), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_rgb"}, rgb, 32'h0);
    chk({tag, "_pixel"}, 32'(gray_pixel), 32'h0);
    chk({tag, "_count"}, 32'(pix_cnt), 32'h0);
  endtask

  // Gaps also raise a spurious converter-ready that GATHER must ignore.
  task automatic push_byte(input logic [7:0] b, input int gap);
    for (int i = 0; i < gap; i++) begin
      byte_valid = 1'b0;
      in_byte    = 8'hA5;
      data_ready = 1'b1;
      in_gray    = 8'hEE;
      chk("gap_ready", 32'(byte_ready), 32'd1);
      step();
    end
    data_ready = 1'b0;
    byte_valid = 1'b1;
    in_byte    = b;
    chk("byte_ready", 32'(byte_ready), 32'd1);
    step();
    byte_valid = 1'b0;
    in_byte    = 8'h00;
  endtask

  task automatic push_three(input vec_t v);
    push_byte(v.r, v.gap);
    push_byte(v.g, v.gap);
    push_byte(v.b, v.gap);
    chk("start_pulse", 32'(gs_start), 32'd1);
    chk("rgb_start", rgb, v.rgb);
    chk("start_no_ready", 32'(byte_ready), 32'd0);
  endtask

  task automatic do_pixel(input vec_t v, input logic [7:0] g,
                          input int exp_cnt);
    push_three(v);
    data_ready = 1'b1;
    in_gray    = 8'hEE;
    step();
    data_ready = 1'b0;
    chk("start_once", 32'(gs_start), 32'd0);
    chk("no_early_emit", 32'(gray_valid), 32'd0);
    for (int i = 0; i < v.clat; i++) begin
      chk("wait_rgb", rgb, v.rgb);
      chk("wait_start", 32'(gs_start), 32'd0);
      chk("wait_byte_ready", 32'(byte_ready), 32'd0);
      step();
    end
    data_ready = 1'b1;
    in_gray    = g;
    step();
    data_ready = 1'b0;
    in_gray    = 8'h00;
    chk("emit_valid", 32'(gray_valid), 32'd1);
    chk("emit_pixel", 32'(gray_pixel), 32'(g));
    for (int i = 0; i < v.rlat; i++) begin
      step();
      chk("hold_valid", 32'(gray_valid), 32'd1);
      chk("hold_pixel", 32'(gray_pixel), 32'(g));
      chk("hold_byte_ready", 32'(byte_ready), 32'd0);
    end
    gray_ready = 1'b1;
    step();
    gray_ready = 1'b0;
    chk("accept_valid", 32'(gray_valid), 32'd0);
    chk("accept_count", 32'(pix_cnt), 32'(exp_cnt));
  endtask

  initial begin
    tbl[0] = '{8'hC8, 8'h10, 8'h40, 0, 1, 0, 32'hC8104000};
    tbl[1] = '{8'h07, 8'hE3, 8'h9A, 2, 2, 4, 32'h07E39A00};
    tbl[2] = '{8'hFF, 8'hFF, 8'hFF, 1, 0, 1, 32'hFFFFFF00};
    tbl[3] = '{8'h5B, 8'h00, 8'hD2, 0, 5, 2, 32'h5B00D200};
    tbl[4] = '{8'hAB, 8'hCD, 8'hEF, 0, 3, 0, 32'hABCDEF00};
    tbl[5] = '{8'h01, 8'h80, 8'h7F, 1, 1, 1, 32'h01807F00};
    basic  = '{8'h12, 8'h34, 8'h56, 0, 3, 0, 32'h12345600};

    n_rst = 1'b0;
    frame_start = 1'b0;
    byte_valid = 1'b0;
    in_byte = 8'h00;
    data_ready = 1'b0;
    in_gray = 8'h00;
    gray_ready = 1'b0;
    step();
    step();
    chk_zero("rst");
    n_rst = 1'b1;
    step();
    step();
    chk_zero("idle");

    // Basic pixel: one-pixel frame completes on the first accept
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    do_pixel(basic, 8'h40, 1);
    chk("basic_rgb_u1", u1_rgb, 32'h12345600);
    chk("basic_pixel_u1", 32'(u1_gray_pixel), 32'h40);
    chk("basic_done_u1", 32'(u1_done), 32'd1);
    chk("basic_count_u1", 32'(u1_pix_cnt), 32'd1);
    chk("basic_ready_u1", 32'(u1_byte_ready), 32'd0);
    chk("basic_notdone", 32'(done), 32'd0);

    // Full frame on the four-pixel instance
    n_rst = 1'b0;
    step();
    n_rst = 1'b1;
    step();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      frame_start = (i == 1);
      do_pixel(tbl[i], luma(tbl[i].r, tbl[i].g, tbl[i].b), i + 1);
      frame_start = 1'b0;
      chk("frame_done", 32'(done), (i == 3) ? 32'd1 : 32'd0);
    end
    step();
    step();
    chk("done_hold", 32'(done), 32'd1);
    chk("done_count", 32'(pix_cnt), 32'd4);
    chk("done_no_ready", 32'(byte_ready), 32'd0);

    // Restart from DONE
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    chk("restart_done", 32'(done), 32'd0);
    chk("restart_count", 32'(pix_cnt), 32'd0);
    chk("restart_ready", 32'(byte_ready), 32'd1);
    do_pixel(tbl[4], luma(tbl[4].r, tbl[4].g, tbl[4].b), 1);
    do_pixel(tbl[5], luma(tbl[5].r, tbl[5].g, tbl[5].b), 2);

    // Third pixel reaches WAIT, then reset lands between edges
    push_three(tbl[2]);
    step();
    chk("pre_reset_count", 32'(pix_cnt), 32'd2);
    #2;
    n_rst = 1'b0;
    #1;
    chk_zero("async");
    step();
    n_rst = 1'b1;
    step();
    step();
    chk_zero("post");

    // A stray byte while IDLE must not be taken into the next pixel
    byte_valid = 1'b1;
    in_byte = 8'h99;
    step();
    byte_valid = 1'b0;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    do_pixel(tbl[0], luma(tbl[0].r, tbl[0].g, tbl[0].b), 1);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
